// File: rtl/fetch_stage.sv
// Instruction fetch: PC, sync I-mem interface, IF/ID register, redirects.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module fetch_stage #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INSTR_W  = 32,
   parameter int                 PC_STEP  = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Stall,
   input  logic [1:0]         JMPSel,
   input  logic [ADDR_W-1:0]  JumpTarget,
   input  logic [ADDR_W-1:0]  RegTarget,
   input  logic               BranchTaken,
   input  logic [ADDR_W-1:0]  BranchTarget,
   output logic [ADDR_W-1:0]  IAddr,
   output logic               IEn,
   input  logic [INSTR_W-1:0] IRData,
   output logic [INSTR_W-1:0] Instr,
   output logic [4:0]         OPcode,
   output logic [2:0]         ALUop,
   output logic [ADDR_W-1:0]  DPC,
   output logic [ADDR_W-1:0]  DPCPlus,
   output logic               DValid,
   output logic               DKill,
   output logic [31:0]        PerfFetched,
   output logic [31:0]        PerfStalled,
   output logic [31:0]        PerfFlushed
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] dpc_q, dpc_d;
   logic              dvalid_q, dvalid_d;
   logic              jump_req;
   logic [ADDR_W-1:0] jump_tgt;

   assign jump_req = dvalid_q & (JMPSel == 2'b01 | JMPSel == 2'b10);
   assign jump_tgt = JMPSel[0] ? JumpTarget : RegTarget;

   always_comb begin
      pc_d     = pc_q + STEP;
      dpc_d    = pc_q;
      dvalid_d = 1'b1;
      unique case (1'b1)
         BranchTaken: begin
            pc_d     = BranchTarget;
            dpc_d    = dpc_q;
            dvalid_d = 1'b0;
         end
         (!BranchTaken && Stall): begin
            pc_d     = pc_q;
            dpc_d    = dpc_q;
            dvalid_d = dvalid_q;
         end
         // fetch already issued at PC+STEP is squashed
         (!BranchTaken && !Stall && jump_req): begin
            pc_d     = jump_tgt;
            dvalid_d = 1'b0;
         end
         default: begin
            pc_d     = pc_q + STEP;
            dpc_d    = pc_q;
            dvalid_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         dpc_q    <= '0;
         dvalid_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         dpc_q    <= dpc_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign IAddr   = pc_q;
   assign IEn     = ~rst_n | ~Stall | BranchTaken;
   assign Instr   = dvalid_q ? IRData : NOP_WORD;
   assign OPcode  = Instr[INSTR_W-1 -: 5];
   assign ALUop   = Instr[INSTR_W-6 -: 3];
   assign DPC     = dpc_q;
   assign DPCPlus = dpc_q + STEP;
   assign DValid  = dvalid_q;
   assign DKill   = BranchTaken;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stalled_q, perf_stalled_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic        en
   );
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction

   always_comb begin
      perf_fetched_d = sat_inc(perf_fetched_q,
                               dvalid_q & ~Stall & ~BranchTaken);
      perf_stalled_d = sat_inc(perf_stalled_q,
                               Stall & ~BranchTaken);
      perf_flushed_d = sat_inc(perf_flushed_q,
                               BranchTaken | (~Stall & jump_req));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_stalled_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stalled_q <= perf_stalled_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end

   assign PerfFetched = perf_fetched_q;
   assign PerfStalled = perf_stalled_q;
   assign PerfFlushed = perf_flushed_q;
`else
   assign PerfFetched = '0;
   assign PerfStalled = '0;
   assign PerfFlushed = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a sync memory model.
// Memory word at byte address a is a>>2.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        Stall;
   logic [1:0]  JMPSel;
   logic [31:0] JumpTarget;
   logic [31:0] RegTarget;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] IAddr;
   logic        IEn;
   logic [31:0] IRData;
   logic [31:0] Instr;
   logic [4:0]  OPcode;
   logic [2:0]  ALUop;
   logic [31:0] DPC;
   logic [31:0] DPCPlus;
   logic        DValid;
   logic        DKill;
   logic [31:0] PerfFetched;
   logic [31:0] PerfStalled;
   logic [31:0] PerfFlushed;

   int n_pass;
   int n_total;

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Stall        (Stall),
      .JMPSel       (JMPSel),
      .JumpTarget   (JumpTarget),
      .RegTarget    (RegTarget),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .IAddr        (IAddr),
      .IEn          (IEn),
      .IRData       (IRData),
      .Instr        (Instr),
      .OPcode       (OPcode),
      .ALUop        (ALUop),
      .DPC          (DPC),
      .DPCPlus      (DPCPlus),
      .DValid       (DValid),
      .DKill        (DKill),
      .PerfFetched  (PerfFetched),
      .PerfStalled  (PerfStalled),
      .PerfFlushed  (PerfFlushed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (IEn) IRData <= IAddr >> 2;

   typedef struct {
      logic        stall;
      logic [1:0]  jsel;
      logic [31:0] jt;
      logic [31:0] rt;
      logic        bt;
      logic [31:0] btgt;
      logic [31:0] iaddr;
      logic        ien;
      logic        dv;
      logic [31:0] dpc;
      logic [31:0] instr;
      logic        dkill;
   } vec_t;

   vec_t vq[$];

   task automatic add(
      input logic        s,
      input logic [1:0]  j,
      input logic [31:0] jt,
      input logic [31:0] rt,
      input logic        b,
      input logic [31:0] btgt,
      input logic [31:0] ia,
      input logic        ie,
      input logic        dv,
      input logic [31:0] dp,
      input logic [31:0] ins,
      input logic        dk
   );
      vec_t v;
      v.stall = s;  v.jsel = j;   v.jt = jt;
      v.rt = rt;    v.bt = b;     v.btgt = btgt;
      v.iaddr = ia; v.ien = ie;   v.dv = dv;
      v.dpc = dp;   v.instr = ins; v.dkill = dk;
      vq.push_back(v);
   endtask

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   initial begin
      vec_t v;
      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      Stall = 1'b1;
      JMPSel = 2'b00;
      JumpTarget = '0;
      RegTarget = '0;
      BranchTaken = 1'b0;
      BranchTarget = '0;

      //  s  j  jt     rt     b  btgt          iaddr        ie dv dpc          instr        dk
      add(0, 0, 0,     0,     0, 0,            32'h0,       1, 0, 0,           0,           0);
      add(0, 0, 0,     0,     0, 0,            32'h4,       1, 1, 32'h0,       0,           0);
      add(0, 0, 0,     0,     0, 0,            32'h8,       1, 1, 32'h4,       1,           0);
      add(1, 0, 0,     0,     0, 0,            32'hC,       0, 1, 32'h8,       2,           0);
      add(1, 0, 0,     0,     0, 0,            32'hC,       0, 1, 32'h8,       2,           0);
      add(1, 0, 0,     0,     0, 0,            32'hC,       0, 1, 32'h8,       2,           0);
      add(0, 0, 0,     0,     0, 0,            32'hC,       1, 1, 32'h8,       2,           0);
      add(0, 1, 'h40,  0,     0, 0,            32'h10,      1, 1, 32'hC,       3,           0);
      add(0, 1, 'h80,  0,     0, 0,            32'h40,      1, 0, 0,           0,           0);
      add(0, 3, 'h80,  0,     0, 0,            32'h44,      1, 1, 32'h40,      'h10,        0);
      add(0, 2, 'h80,  'h200, 0, 0,            32'h48,      1, 1, 32'h44,      'h11,        0);
      add(0, 0, 0,     0,     0, 0,            32'h200,     1, 0, 0,           0,           0);
      add(1, 1, 'h40,  0,     1, 'h100,        32'h204,     1, 1, 32'h200,     'h80,        1);
      add(0, 0, 0,     0,     0, 0,            32'h100,     1, 0, 0,           0,           0);
      add(0, 0, 0,     0,     1, 'hFFFF_FFFC,  32'h104,     1, 1, 32'h100,     'h40,        1);
      add(0, 0, 0,     0,     0, 0,            'hFFFF_FFFC, 1, 0, 0,           0,           0);
      add(0, 0, 0,     0,     0, 0,            32'h0,       1, 1, 'hFFFF_FFFC, 'h3FFF_FFFF, 0);
      add(1, 1, 'h300, 0,     0, 0,            32'h4,       0, 1, 32'h0,       0,           0);
      add(0, 1, 'h300, 0,     0, 0,            32'h4,       1, 1, 32'h0,       0,           0);
      add(0, 0, 0,     0,     0, 0,            32'h300,     1, 0, 0,           0,           0);
      add(0, 0, 0,     0,     0, 0,            32'h304,     1, 1, 32'h300,     'hC0,        0);

      repeat (2) @(negedge clk);
      chk("rst iaddr", IAddr, 32'h0);
      chk("rst ien", {31'b0, IEn}, 32'd1);
      chk("rst dvalid", {31'b0, DValid}, 32'd0);
      chk("rst dpc", DPC, 32'h0);
      chk("rst instr", Instr, 32'h0);
      chk("rst pfetch", PerfFetched, 32'h0);
      chk("rst pstall", PerfStalled, 32'h0);
      chk("rst pflush", PerfFlushed, 32'h0);

      Stall = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         Stall = v.stall;
         JMPSel = v.jsel;
         JumpTarget = v.jt;
         RegTarget = v.rt;
         BranchTaken = v.bt;
         BranchTarget = v.btgt;
         #1;
         chk($sformatf("r%0d iaddr", i), IAddr, v.iaddr);
         chk($sformatf("r%0d ien", i), {31'b0, IEn}, {31'b0, v.ien});
         chk($sformatf("r%0d dvalid", i), {31'b0, DValid}, {31'b0, v.dv});
         chk($sformatf("r%0d instr", i), Instr, v.instr);
         chk($sformatf("r%0d dkill", i), {31'b0, DKill}, {31'b0, v.dkill});
         if (v.dv) begin
            chk($sformatf("r%0d dpc", i), DPC, v.dpc);
            chk($sformatf("r%0d dpcplus", i), DPCPlus, v.dpc + 32'd4);
            chk($sformatf("r%0d opcode", i), {27'b0, OPcode},
                {27'b0, v.instr[31:27]});
            chk($sformatf("r%0d aluop", i), {29'b0, ALUop},
                {29'b0, v.instr[26:24]});
         end
         @(negedge clk);
      end

`ifdef FETCH_PERF_CNT_EN
      chk("perf fetched", PerfFetched, 32'd9);
      chk("perf stalled", PerfStalled, 32'd4);
      chk("perf flushed", PerfFlushed, 32'd5);
      force dut.perf_stalled_q = 32'hFFFF_FFFE;
      JMPSel = 2'b00;
      Stall = 1'b1;
      #1 release dut.perf_stalled_q;
      chk("sat preload", PerfStalled, 32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("sat stall%0d", k), PerfStalled, 32'hFFFF_FFFF);
      end
`else
      chk("perf fetched off", PerfFetched, 32'h0);
      chk("perf stalled off", PerfStalled, 32'h0);
      chk("perf flushed off", PerfFlushed, 32'h0);
`endif

      Stall = 1'b1;
      JMPSel = 2'b01;
      JumpTarget = 32'h500;
      BranchTaken = 1'b1;
      BranchTarget = 32'h600;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst iaddr", IAddr, 32'h0);
      chk("midrst dvalid", {31'b0, DValid}, 32'd0);
      chk("midrst dpc", DPC, 32'h0);
      chk("midrst instr", Instr, 32'h0);
      @(negedge clk);
      Stall = 1'b0;
      JMPSel = 2'b00;
      BranchTaken = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel iaddr", IAddr, 32'h0);
      chk("rel ien", {31'b0, IEn}, 32'd1);
      @(negedge clk);
      #1;
      chk("rel2 iaddr", IAddr, 32'h4);
      chk("rel2 dvalid", {31'b0, DValid}, 32'd1);
      chk("rel2 dpc", DPC, 32'h0);
      chk("rel2 instr", Instr, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
